// File: rtl/nf2_reg_arb.sv
// Two-master register-bus arbiter in front of nf2_reg_grp: alternating grant,
// one outstanding transaction, and a completion timeout that returns an error.
module nf2_reg_arb #(
    parameter int         ADDR_WIDTH = 27,
    parameter int         DATA_WIDTH = 32,
    parameter logic [9:0] TIMEOUT    = 10'd1023
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  m0_req,
    input  logic                  m0_rd_wr_L,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wr_data,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rd_data,
    output logic                  m0_err,

    input  logic                  m1_req,
    input  logic                  m1_rd_wr_L,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wr_data,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rd_data,
    output logic                  m1_err,

    output logic                  fifo_empty,
    input  logic                  fifo_rd_en,
    output logic                  bus_rd_wr_L,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wr_data,
    input  logic                  bus_rd_vld,
    input  logic [DATA_WIDTH-1:0] bus_rd_data,
    input  logic                  out_ack,
    output logic                  arb_busy
);

    localparam logic [DATA_WIDTH-1:0] TIMEOUT_DATA = DATA_WIDTH'(32'hDEADBEEF);

    typedef enum logic [2:0] {IDLE, ISSUE, HOLD, WAIT, RESP} state_t;

    state_t                  state, state_nxt;
    logic                    gnt, gnt_nxt;
    logic                    last_gnt, last_gnt_nxt;
    logic [9:0]              cnt, cnt_nxt;
    logic                    rd_wr_L_nxt;
    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic [DATA_WIDTH-1:0]   wr_data_nxt;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_nxt;
    logic                    err_q, err_nxt;
    logic                    sel;
    logic                    done;
    logic                    first_wait;

    // Both requesting: the port not served last wins; otherwise the lone requester.
    assign sel        = (m0_req && m1_req) ? ~last_gnt : m1_req;
    assign done       = bus_rd_wr_L ? bus_rd_vld : out_ack;
    // The counter still holds its load value only in the first WAIT cycle, where a
    // completion may be a stale acknowledge from the previous transaction.
    assign first_wait = (cnt == TIMEOUT);

    always_comb begin
        // NOTE: every next-state value defaults to its current value first, so no
        // path through the case statement can leave one unassigned and infer a latch.
        state_nxt    = state;
        gnt_nxt      = gnt;
        last_gnt_nxt = last_gnt;
        cnt_nxt      = cnt;
        rd_wr_L_nxt  = bus_rd_wr_L;
        addr_nxt     = bus_addr;
        wr_data_nxt  = bus_wr_data;
        rd_data_nxt  = rd_data_q;
        err_nxt      = err_q;

        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    gnt_nxt     = sel;
                    rd_wr_L_nxt = sel ? m1_rd_wr_L : m0_rd_wr_L;
                    addr_nxt    = sel ? m1_addr    : m0_addr;
                    wr_data_nxt = sel ? m1_wr_data : m0_wr_data;
                    state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                if (fifo_rd_en) state_nxt = HOLD;
            end
            HOLD: begin
                cnt_nxt   = TIMEOUT;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (done && !first_wait) begin
                    rd_data_nxt = bus_rd_wr_L ? bus_rd_data : '0;
                    err_nxt     = 1'b0;
                    state_nxt   = RESP;
                end else if (cnt == 10'd0) begin
                    rd_data_nxt = bus_rd_wr_L ? TIMEOUT_DATA : '0;
                    err_nxt     = 1'b1;
                    state_nxt   = RESP;
                end else begin
                    cnt_nxt = cnt - 10'd1;
                end
            end
            RESP: begin
                last_gnt_nxt = gnt;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            gnt         <= 1'b0;
            last_gnt    <= 1'b1;
            cnt         <= 10'd0;
            bus_rd_wr_L <= 1'b1;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            rd_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values computed above, independent of statement order.
            state       <= state_nxt;
            gnt         <= gnt_nxt;
            last_gnt    <= last_gnt_nxt;
            cnt         <= cnt_nxt;
            bus_rd_wr_L <= rd_wr_L_nxt;
            bus_addr    <= addr_nxt;
            bus_wr_data <= wr_data_nxt;
            rd_data_q   <= rd_data_nxt;
            err_q       <= err_nxt;
        end
    end

    assign fifo_empty = (state != ISSUE);
    assign arb_busy   = (state != IDLE);

    // Responses are steered to the granted port only; the other port sees zeros.
    assign m0_ack     = (state == RESP) && !gnt;
    assign m1_ack     = (state == RESP) &&  gnt;
    assign m0_rd_data = m0_ack ? rd_data_q : '0;
    assign m1_rd_data = m1_ack ? rd_data_q : '0;
    assign m0_err     = m0_ack && err_q;
    assign m1_err     = m1_ack && err_q;

endmodule
